dpram_sync_multiport: RTL and testbench

- Parametrised, synthesizable successor to the DPI-backed dual-read RAM helper.
- Provides RD_PORTS independent read ports and one bit-masked write port, with registered read latency (1 or 2) and per-port valid.
- Performs a hardware zero-clear sweep after reset.
- Used as the on-chip scratch/data memory in the simulation core and in FPGA builds, where DPI calls are not available.

---
 rtl/dpram_sync_multiport.sv | 137 +++++++++++++
 tb/tb_dpram_sync_multiport.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_sync_multiport.sv
// Multi-read-port synchronous RAM with one bit-masked write port and a zero-clear sweep after reset.
// Define DPRAM_WR_BYPASS_EN for write-first same-index behaviour (default is read-first).
module dpram_sync_multiport #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int RD_PORTS = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_busy,
  input  logic [RD_PORTS-1:0]          ren,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata,
  output logic [RD_PORTS-1:0]          rvalid,
  input  logic                         wen,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W-1:0]            wmask,
  output logic                         addr_err
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] d,
                                               input logic [DATA_W-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt;
  logic                active;
  logic                wr_ok;
  logic                wr_oor;
  logic [RD_PORTS-1:0] rd_oor;

  always_comb begin
    state_nx = state;
    if (state == CLEAR && cnt == LAST_IDX) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_nx;
      init_busy <= (state_nx == CLEAR);
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  assign active = (state == IDLE) && !rst;
  assign wr_ok  = active && wen && in_range(waddr);
  assign wr_oor = active && wen && !in_range(waddr);

  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt] <= '0;
    else if (wr_ok)     mem[waddr] <= merge(mem[waddr], wdata, wmask);
  end

  always_ff @(posedge clk) begin
    if (rst)                      addr_err <= 1'b0;
    else if (wr_oor || |rd_oor)   addr_err <= 1'b1;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic              rd_go;
    logic              rd_ok;
    logic [DATA_W-1:0] word;
    logic              vld_p0;

    assign ra        = raddr[p*ADDR_W +: ADDR_W];
    assign rd_go     = active && ren[p];
    assign rd_ok     = in_range(ra);
    assign rd_oor[p] = rd_go && !rd_ok;

`ifdef DPRAM_WR_BYPASS_EN
    assign word = (wr_ok && waddr == ra) ? merge(mem[ra], wdata, wmask) : mem[ra];
`else
    assign word = mem[ra];
`endif

    // stage p0: array read register
    always_ff @(posedge clk) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= rd_go;
    end

    if (RD_LAT == 1) begin : g_lat1
      logic [DATA_W-1:0] data_p0;

      always_ff @(posedge clk) begin
        if (rst)        data_p0 <= '0;
        else if (rd_go) data_p0 <= rd_ok ? word : '0;
      end

      assign rdata[p*DATA_W +: DATA_W] = data_p0;
      assign rvalid[p]                 = vld_p0;
    end else begin : g_lat2
      logic [DATA_W-1:0] data_p0;
      logic [DATA_W-1:0] data_p1;
      logic              vld_p1;

      always_ff @(posedge clk) begin
        if (rd_go) data_p0 <= rd_ok ? word : '0;
      end

      // stage p1: output register
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign rdata[p*DATA_W +: DATA_W] = data_p1;
      assign rvalid[p]                 = vld_p1;
    end
  end

endmodule

// File: tb/tb_dpram_sync_multiport.sv
// Randomized and directed bench for dpram_sync_multiport against an array/queue reference model.
module tb_dpram_sync_multiport;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 12;
  localparam int RD_PORTS = 2;
  localparam int RD_LAT   = 1;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       init_busy;
  logic [RD_PORTS-1:0]        ren;
  logic [RD_PORTS*ADDR_W-1:0] raddr;
  logic [RD_PORTS*DATA_W-1:0] rdata;
  logic [RD_PORTS-1:0]        rvalid;
  logic                       wen;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic [DATA_W-1:0]          wmask;
  logic                       addr_err;

  always #5 clk = ~clk;

  dpram_sync_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_PORTS(RD_PORTS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy), .ren(ren), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .addr_err(addr_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {int due; int port; logic [DATA_W-1:0] data;} rd_t;

  logic [DATA_W-1:0] mem_m [DEPTH];
  rd_t               pend[$];
  logic [DATA_W-1:0] exp_d [RD_PORTS];
  logic              exp_v [RD_PORTS];
  logic              busy_m = 1'b1;
  logic              err_m  = 1'b0;
  int                clr_left = 0;
  int                edge_n = 0;
  int                busy_seen = 0;

  // Advance one clock: predict this edge from the current inputs, then compare.
  task automatic tick();
    rd_t               keep[$];
    int                a;
    logic [DATA_W-1:0] d;
    edge_n++;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      pend.delete();
      busy_m   = 1'b1;
      clr_left = DEPTH;
      err_m    = 1'b0;
      for (int p = 0; p < RD_PORTS; p++) exp_d[p] = '0;
    end else if (busy_m) begin
      clr_left--;
      if (clr_left == 0) busy_m = 1'b0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        if (ren[p]) begin
          a = int'(raddr[p*ADDR_W +: ADDR_W]);
          if (a < DEPTH) begin
            d = mem_m[a];
`ifdef DPRAM_WR_BYPASS_EN
            if (wen && int'(waddr) == a) d = (d & ~wmask) | (wdata & wmask);
`endif
          end else begin
            d = '0;
            err_m = 1'b1;
          end
          pend.push_back('{edge_n + RD_LAT - 1, p, d});
        end
      end
      if (wen) begin
        if (int'(waddr) < DEPTH) mem_m[int'(waddr)] = (mem_m[int'(waddr)] & ~wmask) | (wdata & wmask);
        else err_m = 1'b1;
      end
    end
    for (int p = 0; p < RD_PORTS; p++) exp_v[p] = 1'b0;
    foreach (pend[i]) begin
      if (pend[i].due == edge_n) begin
        exp_v[pend[i].port] = 1'b1;
        exp_d[pend[i].port] = pend[i].data;
      end else begin
        keep.push_back(pend[i]);
      end
    end
    pend = keep;
    @(posedge clk);
    #1;
    for (int p = 0; p < RD_PORTS; p++) begin
      check($sformatf("rvalid%0d@%0d", p, edge_n), {63'b0, rvalid[p]}, {63'b0, exp_v[p]});
      check($sformatf("rdata%0d@%0d", p, edge_n), rdata[p*DATA_W +: DATA_W], exp_d[p]);
    end
    check($sformatf("init_busy@%0d", edge_n), {63'b0, init_busy}, {63'b0, busy_m});
    check($sformatf("addr_err@%0d", edge_n), {63'b0, addr_err}, {63'b0, err_m});
    if (init_busy) busy_seen++;
  endtask

  task automatic idle();
    ren = '0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0; wmask = '0;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
    idle();
    wen = 1'b1; waddr = ADDR_W'(a); wdata = d; wmask = m;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [RD_PORTS-1:0] en, input int a0, input int a1);
    idle();
    ren = en;
    raddr[0 +: ADDR_W]      = ADDR_W'(a0);
    raddr[ADDR_W +: ADDR_W] = ADDR_W'(a1);
    tick();
    idle();
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < RD_LAT - 1; i++) tick();
  endtask

  task automatic sweep_from_reset();
    idle();
    rst = 1'b1;
    busy_seen = 0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    for (int p = 0; p < RD_PORTS; p++) begin exp_d[p] = '0; exp_v[p] = 1'b0; end

    // Sweep with traffic applied throughout the clear phase
    sweep_from_reset();
    for (int i = 0; i < DEPTH - 1; i++) begin
      ren = RD_PORTS'($urandom); raddr = RD_PORTS*ADDR_W'($urandom);
      wen = 1'b1; waddr = ADDR_W'($urandom); wdata = {$urandom, $urandom}; wmask = '1;
      tick();
    end
    idle();
    tick(); tick();
    check("busy_len", 64'(busy_seen), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) do_read(2'b11, i, DEPTH - 1 - i);
    drain(); tick();

    // Reset mid-sweep restarts the full clear
    do_write(2, 64'hDEAD_BEEF_0123_4567, '1);
    sweep_from_reset();
    for (int i = 0; i < 7; i++) tick();
    sweep_from_reset();
    for (int i = 0; i < DEPTH + 2; i++) tick();
    check("busy_len_restart", 64'(busy_seen), 64'(DEPTH));
    do_read(2'b01, 2, 0);
    drain();
    check("restart_cleared", rdata[DATA_W-1:0], 64'h0);

    // Masked write
    do_write(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000);
    do_read(2'b01, 3, 0);
    drain();
    check("mask_rd", rdata[DATA_W-1:0], 64'h0000_0000_FFFF_0000);
    check("mask_vld", {63'b0, rvalid[0]}, 64'h1);
    tick();

    // Back-to-back on both ports
    do_write(5, 64'hA5, '1);
    do_write(9, 64'h5A, '1);
    do_read(2'b11, 5, 9);
    do_read(2'b11, 9, 5);
    do_read(2'b11, 5, 9);
    drain(); tick(); tick();

    // Same-index read and write in one cycle
    do_write(7, 64'h11, '1);
    idle();
    wen = 1'b1; waddr = 4'd7; wdata = 64'h22; wmask = '1;
    ren = 2'b01; raddr[0 +: ADDR_W] = 4'd7;
    tick();
    drain();
`ifdef DPRAM_WR_BYPASS_EN
    check("collide", rdata[DATA_W-1:0], 64'h22);
`else
    check("collide", rdata[DATA_W-1:0], 64'h11);
`endif
    do_read(2'b01, 7, 0);
    drain();
    check("collide_after", rdata[DATA_W-1:0], 64'h22);

    // Out-of-range accesses
    do_write(13, '1, '1);
    check("oor_wr_err", {63'b0, addr_err}, 64'h1);
    do_read(2'b11, 14, 13);
    drain();
    check("oor_rd_vld", {63'b0, rvalid[1]}, 64'h1);
    check("oor_rd_data", rdata[DATA_W +: DATA_W], 64'h0);
    for (int i = 0; i < 4; i++) tick();
    check("oor_sticky", {63'b0, addr_err}, 64'h1);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      ren   = RD_PORTS'($urandom);
      for (int p = 0; p < RD_PORTS; p++)
        raddr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      wen   = $urandom_range(0, 1) == 1;
      waddr = ($urandom_range(0, 3) == 0) ? raddr[0 +: ADDR_W] : ADDR_W'($urandom);
      wdata = {$urandom, $urandom};
      wmask = ($urandom_range(0, 2) == 0) ? '1 : {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < DEPTH + 2; i++) tick();

    sweep_from_reset();
    check("err_cleared", {63'b0, addr_err}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
